// File: rtl/rtc_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rtc_reset_sequencer                                             |
// | Purpose  : Releases per-subsystem active-low resets in a fixed order       |
// |            (timekeeping core, I2C/RTC interface, display driver) once the  |
// |            synchronized reset is deasserted and the PLL lock is stable.    |
// |            All stage resets reassert together on reset, lock loss or soft  |
// |            reset request.                                                  |
// | Options  : RTC_SOFT_RESET_EN - enables soft_rst_req and SOFT_ASSERT state. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rtc_reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 16,
  parameter int LOCK_FILTER = 8
) (
  input  logic                  clk,
  input  logic                  ext_reset,
  input  logic                  sync_resetn,
  input  logic                  pll_locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_rstn,
  output logic                  seq_done
);

  localparam int c_lock_w = $clog2(LOCK_FILTER + 1);
  localparam int c_dly_w  = $clog2(STAGE_DELAY + 1);
  localparam int c_idx_w  = $clog2(NUM_STAGES + 1);

  localparam logic [c_lock_w-1:0] c_lock_last = c_lock_w'(LOCK_FILTER - 1);
  localparam logic [c_dly_w-1:0]  c_dly_last  = c_dly_w'(STAGE_DELAY - 1);
  localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3
`ifdef RTC_SOFT_RESET_EN
    ,
    ST_SOFT_ASSERT = 3'd4
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic                    lk_meta_q;
  logic                    lk_s_q;
  logic [c_lock_w-1:0]     lock_cnt_q, lock_cnt_d;
  logic [c_dly_w-1:0]      dly_cnt_q, dly_cnt_d;
  logic [c_idx_w-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_rstn_q, stage_rstn_d;
  logic                    seq_done_q, seq_done_d;

`ifndef RTC_SOFT_RESET_EN
  // The port is kept for a uniform interface but has no function in this build.
  logic unused_soft_rst_req;
  assign unused_soft_rst_req = soft_rst_req;
`endif

  // Next-state logic: aborts first (reset, then lock loss), then normal sequencing.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    dly_cnt_d    = dly_cnt_q;
    idx_d        = idx_q;
    stage_rstn_d = stage_rstn_q;
    seq_done_d   = seq_done_q;

    if (!sync_resetn) begin
      state_d      = ST_HOLD;
      lock_cnt_d   = '0;
      dly_cnt_d    = '0;
      idx_d        = '0;
      stage_rstn_d = '0;
      seq_done_d   = 1'b0;
    end else if (!lk_s_q && (state_q != ST_HOLD) && (state_q != ST_WAIT_LOCK)) begin
      // Lock lost while sequencing or running: drop everything and re-filter lock.
      state_d      = ST_WAIT_LOCK;
      lock_cnt_d   = '0;
      dly_cnt_d    = '0;
      idx_d        = '0;
      stage_rstn_d = '0;
      seq_done_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d      = ST_WAIT_LOCK;
          lock_cnt_d   = '0;
          stage_rstn_d = '0;
          seq_done_d   = 1'b0;
        end
        ST_WAIT_LOCK: begin
          if (!lk_s_q) begin
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + c_lock_w'(1);
            if (lock_cnt_q == c_lock_last) begin
              state_d   = ST_RELEASE;
              dly_cnt_d = '0;
              idx_d     = '0;
            end
          end
        end
        ST_RELEASE: begin
          if (dly_cnt_q == c_dly_last) begin
            dly_cnt_d = '0;
            idx_d     = idx_q + c_idx_w'(1);
            // Stages only ever get set here; any reassertion clears all bits at once.
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (idx_q == c_idx_w'(i)) stage_rstn_d[i] = 1'b1;
            end
            if (idx_q == c_idx_last) begin
              state_d    = ST_RUN;
              seq_done_d = 1'b1;
            end
          end else begin
            dly_cnt_d = dly_cnt_q + c_dly_w'(1);
          end
        end
        ST_RUN: begin
`ifdef RTC_SOFT_RESET_EN
          if (soft_rst_req) begin
            state_d      = ST_SOFT_ASSERT;
            dly_cnt_d    = '0;
            idx_d        = '0;
            stage_rstn_d = '0;
            seq_done_d   = 1'b0;
          end
`endif
        end
`ifdef RTC_SOFT_RESET_EN
        ST_SOFT_ASSERT: begin
          // Hold all stages low for STAGE_DELAY cycles, then resequence without re-filtering lock.
          if (dly_cnt_q == c_dly_last) begin
            state_d   = ST_RELEASE;
            dly_cnt_d = '0;
            idx_d     = '0;
          end else begin
            dly_cnt_d = dly_cnt_q + c_dly_w'(1);
          end
        end
`endif
        default: begin
          state_d      = ST_HOLD;
          lock_cnt_d   = '0;
          dly_cnt_d    = '0;
          idx_d        = '0;
          stage_rstn_d = '0;
          seq_done_d   = 1'b0;
        end
      endcase
    end
  end

  // State, counters, registered outputs and the two-flop lock synchronizer.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      lk_meta_q    <= 1'b0;
      lk_s_q       <= 1'b0;
      state_q      <= ST_HOLD;
      lock_cnt_q   <= '0;
      dly_cnt_q    <= '0;
      idx_q        <= '0;
      stage_rstn_q <= '0;
      seq_done_q   <= 1'b0;
    end else begin
      lk_meta_q    <= pll_locked;
      lk_s_q       <= lk_meta_q;
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      dly_cnt_q    <= dly_cnt_d;
      idx_q        <= idx_d;
      stage_rstn_q <= stage_rstn_d;
      seq_done_q   <= seq_done_d;
    end
  end

  assign stage_rstn = stage_rstn_q;
  assign seq_done   = seq_done_q;

endmodule
`default_nettype wire
